// File: rtl/speicher_arbiter.sv
// speicher_arbiter: round-robin sharing of one single-port RAM between the instruction
// fetch port and the data port, with a per-transaction watchdog.
module speicher_arbiter #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 64
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              ILesen,
   input  logic [ADDR_W-1:0] IAdresse,
   output logic [DATA_W-1:0] IDaten,
   output logic              IGeladen,
   input  logic              DLesen,
   input  logic              DSchreiben,
   input  logic [ADDR_W-1:0] DAdresse,
   input  logic [DATA_W-1:0] DDatenRein,
   output logic [DATA_W-1:0] DDatenRaus,
   output logic              DGeladen,
   output logic              DGespeichert,
   output logic              RAMLesenAn,
   output logic              RAMSchreibenAn,
   output logic [ADDR_W-1:0] RAMAdresse,
   output logic [DATA_W-1:0] RAMDatenRein,
   input  logic [DATA_W-1:0] RAMDatenRaus,
   input  logic              RAMDatenBereit,
   input  logic              RAMDatenGeschrieben,
   output logic              Zeitueberschreitung
);
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_END = CW'(TIMEOUT - 1);
   localparam bit WD_ON = (TIMEOUT != 0);

   typedef enum logic [2:0] {LEERLAUF, INSTR, DATEN_L, DATEN_S, ABKLINGEN} state_t;

   state_t            state_q, state_d;
   logic              last_daten_q, last_daten_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] idaten_q, idaten_d;
   logic [DATA_W-1:0] ddaten_q, ddaten_d;
   logic              igeladen_q, igeladen_d;
   logic              dgeladen_q, dgeladen_d;
   logic              dgespeichert_q, dgespeichert_d;
   logic              zeit_q, zeit_d;
   logic              grant_i, grant_d, busy, comp, abort, fin;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q        <= LEERLAUF;
         last_daten_q   <= 1'b1;
         cnt_q          <= '0;
         addr_q         <= '0;
         wdata_q        <= '0;
         idaten_q       <= '0;
         ddaten_q       <= '0;
         igeladen_q     <= 1'b0;
         dgeladen_q     <= 1'b0;
         dgespeichert_q <= 1'b0;
         zeit_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         last_daten_q   <= last_daten_d;
         cnt_q          <= cnt_d;
         addr_q         <= addr_d;
         wdata_q        <= wdata_d;
         idaten_q       <= idaten_d;
         ddaten_q       <= ddaten_d;
         igeladen_q     <= igeladen_d;
         dgeladen_q     <= dgeladen_d;
         dgespeichert_q <= dgespeichert_d;
         zeit_q         <= zeit_d;
      end
   end

   // In ABKLINGEN only the port not just served may be granted, so a held request is never served twice.
   always_comb begin
      grant_i = ILesen & (((state_q == LEERLAUF) & (!(DLesen | DSchreiben) | last_daten_q)) |
                          ((state_q == ABKLINGEN) & last_daten_q));
      grant_d = (DLesen | DSchreiben) & (((state_q == LEERLAUF) & (!ILesen | !last_daten_q)) |
                                         ((state_q == ABKLINGEN) & !last_daten_q));
      busy    = (state_q == INSTR) | (state_q == DATEN_L) | (state_q == DATEN_S);
      comp    = (((state_q == INSTR) | (state_q == DATEN_L)) & RAMDatenBereit) |
                ((state_q == DATEN_S) & RAMDatenGeschrieben);
      abort   = busy & !comp & WD_ON & (cnt_q == CNT_END);
      fin     = comp | abort;
      state_d = grant_i ? INSTR :
                grant_d ? (DSchreiben ? DATEN_S : DATEN_L) :
                fin ? ABKLINGEN :
                (state_q == ABKLINGEN) ? LEERLAUF : state_q;
   end

   always_comb begin
      igeladen_d     = fin & (state_q == INSTR);
      dgeladen_d     = fin & (state_q == DATEN_L);
      dgespeichert_d = fin & (state_q == DATEN_S);
      zeit_d         = abort;
      idaten_d       = igeladen_d ? (comp ? RAMDatenRaus : '0) : idaten_q;
      ddaten_d       = dgeladen_d ? (comp ? RAMDatenRaus : '0) : ddaten_q;
      addr_d         = grant_i ? IAdresse : grant_d ? DAdresse : addr_q;
      wdata_d        = (grant_d & DSchreiben) ? DDatenRein : wdata_q;
      last_daten_d   = grant_i ? 1'b0 : grant_d ? 1'b1 : last_daten_q;
      cnt_d          = (grant_i | grant_d) ? '0 : busy ? cnt_q + CW'(1) : cnt_q;
   end

   always_comb begin
      RAMLesenAn          = (state_q == INSTR) | (state_q == DATEN_L);
      RAMSchreibenAn      = (state_q == DATEN_S);
      RAMAdresse          = addr_q;
      RAMDatenRein        = wdata_q;
      IDaten              = idaten_q;
      IGeladen            = igeladen_q;
      DDatenRaus          = ddaten_q;
      DGeladen            = dgeladen_q;
      DGespeichert        = dgespeichert_q;
      Zeitueberschreitung = zeit_q;
   end
endmodule

// File: tb/tb_speicher_arbiter.sv
// tb_speicher_arbiter: directed tests of the shared-RAM arbiter against a small
// negedge-driven RAM model with programmable completion latency.
module tb_speicher_arbiter;
   logic        Clock = 1'b0;
   logic        Reset = 1'b0;
   logic        ILesen = 1'b0;
   logic [7:0]  IAdresse = '0;
   logic [31:0] IDaten;
   logic        IGeladen;
   logic        DLesen = 1'b0;
   logic        DSchreiben = 1'b0;
   logic [7:0]  DAdresse = '0;
   logic [31:0] DDatenRein = '0;
   logic [31:0] DDatenRaus;
   logic        DGeladen;
   logic        DGespeichert;
   logic        RAMLesenAn;
   logic        RAMSchreibenAn;
   logic [7:0]  RAMAdresse;
   logic [31:0] RAMDatenRein;
   logic [31:0] RAMDatenRaus = '0;
   logic        RAMDatenBereit = 1'b0;
   logic        RAMDatenGeschrieben = 1'b0;
   logic        Zeitueberschreitung;

   logic [31:0] mem [256];
   int ram_lat = 1;
   int ram_cnt = 0;
   int total = 0;
   int bad = 0;

   speicher_arbiter #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(8)) dut (
      .Clock(Clock), .Reset(Reset),
      .ILesen(ILesen), .IAdresse(IAdresse), .IDaten(IDaten), .IGeladen(IGeladen),
      .DLesen(DLesen), .DSchreiben(DSchreiben), .DAdresse(DAdresse),
      .DDatenRein(DDatenRein), .DDatenRaus(DDatenRaus), .DGeladen(DGeladen),
      .DGespeichert(DGespeichert), .RAMLesenAn(RAMLesenAn), .RAMSchreibenAn(RAMSchreibenAn),
      .RAMAdresse(RAMAdresse), .RAMDatenRein(RAMDatenRein), .RAMDatenRaus(RAMDatenRaus),
      .RAMDatenBereit(RAMDatenBereit), .RAMDatenGeschrieben(RAMDatenGeschrieben),
      .Zeitueberschreitung(Zeitueberschreitung)
   );

   always #5 Clock = ~Clock;

   // RAM answers ram_lat cycles after the strobe was first seen; ram_lat=0 never answers.
   always @(negedge Clock) begin
      RAMDatenBereit = 1'b0;
      RAMDatenGeschrieben = 1'b0;
      if (!Reset) begin
         ram_cnt = 0;
         mem[8'h10] = 32'hDEAD_BEEF;
         mem[8'h20] = 32'hA5A5_0020;
         mem[8'h30] = 32'h5A5A_0030;
      end else if (RAMLesenAn || RAMSchreibenAn) begin
         ram_cnt++;
         if (ram_lat > 0 && ram_cnt == ram_lat + 1) begin
            if (RAMLesenAn) begin
               RAMDatenRaus = mem[RAMAdresse];
               RAMDatenBereit = 1'b1;
            end else begin
               mem[RAMAdresse] = RAMDatenRein;
               RAMDatenGeschrieben = 1'b1;
            end
         end
      end else ram_cnt = 0;
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b0;
      #12;
      if (RAMLesenAn !== 1'b0 || RAMSchreibenAn !== 1'b0) begin bad++; $display("FAIL rst_strobes: got %b%b want 00", RAMLesenAn, RAMSchreibenAn); end
      total++;
      if ({IGeladen, DGeladen, DGespeichert, Zeitueberschreitung} !== 4'b0000) begin bad++; $display("FAIL rst_pulses: got %b want 0000", {IGeladen, DGeladen, DGespeichert, Zeitueberschreitung}); end
      total++;
      if (IDaten !== 32'h0 || DDatenRaus !== 32'h0) begin bad++; $display("FAIL rst_data: got %h %h want 0 0", IDaten, DDatenRaus); end
      total++;
      if (RAMAdresse !== 8'h0 || RAMDatenRein !== 32'h0) begin bad++; $display("FAIL rst_ram_bus: got %h %h want 0 0", RAMAdresse, RAMDatenRein); end
      total++;
      @(posedge Clock);
      #1;
      Reset = 1'b1;
      tick();
   endtask

   task automatic test_single_fetch();
      ram_lat = 1;
      ILesen = 1'b1;
      IAdresse = 8'h10;
      tick();
      if (RAMLesenAn !== 1'b1 || RAMAdresse !== 8'h10) begin bad++; $display("FAIL fetch_grant: got rd=%b adr=%h want rd=1 adr=10", RAMLesenAn, RAMAdresse); end
      total++;
      IAdresse = 8'h77;
      tick();
      if (RAMLesenAn !== 1'b1 || IGeladen !== 1'b0 || RAMAdresse !== 8'h10) begin bad++; $display("FAIL fetch_hold: got rd=%b done=%b adr=%h want 1 0 10", RAMLesenAn, IGeladen, RAMAdresse); end
      total++;
      tick();
      if (IGeladen !== 1'b1 || RAMLesenAn !== 1'b0) begin bad++; $display("FAIL fetch_done: got done=%b rd=%b want 1 0", IGeladen, RAMLesenAn); end
      total++;
      if (IDaten !== 32'hDEAD_BEEF) begin bad++; $display("FAIL fetch_data: got %h want deadbeef", IDaten); end
      total++;
      ILesen = 1'b0;
      tick();
      if (IGeladen !== 1'b0 || RAMLesenAn !== 1'b0) begin bad++; $display("FAIL fetch_pulse: got done=%b rd=%b want 0 0", IGeladen, RAMLesenAn); end
      total++;
   endtask

   task automatic test_write_read();
      int c;
      bit rd_seen;
      ram_lat = 2;
      DSchreiben = 1'b1;
      DAdresse = 8'h05;
      DDatenRein = 32'h1234_5678;
      c = 0;
      rd_seen = 0;
      do begin
         tick();
         c++;
         if (RAMLesenAn) rd_seen = 1;
      end while (!DGespeichert && c < 20);
      if (c !== 4) begin bad++; $display("FAIL wr_latency: got %0d want 4", c); end
      total++;
      if (rd_seen !== 1'b0) begin bad++; $display("FAIL wr_no_read: got %b want 0", rd_seen); end
      total++;
      if (mem[8'h05] !== 32'h1234_5678) begin bad++; $display("FAIL wr_mem: got %h want 12345678", mem[8'h05]); end
      total++;
      DSchreiben = 1'b0;
      DDatenRein = 32'h0;
      tick();
      if (DGespeichert !== 1'b0) begin bad++; $display("FAIL wr_pulse: got %b want 0", DGespeichert); end
      total++;
      DLesen = 1'b1;
      c = 0;
      do begin
         tick();
         c++;
      end while (!DGeladen && c < 20);
      if (c !== 4 || DDatenRaus !== 32'h1234_5678) begin bad++; $display("FAIL rd_back: got cyc=%0d data=%h want 4 12345678", c, DDatenRaus); end
      total++;
      DLesen = 1'b0;
      tick();
      if (DGeladen !== 1'b0 || DDatenRaus !== 32'h1234_5678) begin bad++; $display("FAIL rd_hold: got done=%b data=%h want 0 12345678", DGeladen, DDatenRaus); end
      total++;
   endtask

   task automatic test_contention();
      int c, n, prev, ic, dc;
      bit pend_i, pend_d;
      logic [7:0] seq;
      ram_lat = 1;
      IAdresse = 8'h20;
      DAdresse = 8'h30;
      ILesen = 1'b1;
      DLesen = 1'b1;
      c = 0; n = 0; prev = 0; ic = 0; dc = 0; pend_i = 0; pend_d = 0; seq = '0;
      while (n < 8 && c < 100) begin
         tick();
         c++;
         if (pend_i) begin ILesen = (ic < 4); pend_i = 0; end
         if (pend_d) begin DLesen = (dc < 4); pend_d = 0; end
         if (IGeladen || DGeladen) begin
            if (n > 0) begin
               if (c - prev !== 3) begin bad++; $display("FAIL cont_gap%0d: got %0d want 3", n, c - prev); end
               total++;
            end
            prev = c;
         end
         if (IGeladen) begin
            if (IDaten !== 32'hA5A5_0020) begin bad++; $display("FAIL cont_idata%0d: got %h want a5a50020", n, IDaten); end
            total++;
            seq[n] = 1'b1;
            ILesen = 1'b0;
            pend_i = 1;
            ic++;
            n++;
         end
         if (DGeladen) begin
            if (DDatenRaus !== 32'h5A5A_0030) begin bad++; $display("FAIL cont_ddata%0d: got %h want 5a5a0030", n, DDatenRaus); end
            total++;
            DLesen = 1'b0;
            pend_d = 1;
            dc++;
            n++;
         end
      end
      if (n !== 8 || seq !== 8'h55) begin bad++; $display("FAIL cont_order: got n=%0d seq=%b want 8 01010101", n, seq); end
      total++;
      ILesen = 1'b0;
      DLesen = 1'b0;
   endtask

   task automatic test_timeout();
      int c, strobes;
      bit zs;
      ram_lat = 0;
      ILesen = 1'b1;
      IAdresse = 8'h40;
      c = 0;
      strobes = 0;
      do begin
         tick();
         c++;
         if (RAMLesenAn) strobes++;
      end while (!IGeladen && c < 20);
      if (c !== 9 || strobes !== 8) begin bad++; $display("FAIL to_latency: got cyc=%0d strobes=%0d want 9 8", c, strobes); end
      total++;
      if (Zeitueberschreitung !== 1'b1 || IDaten !== 32'h0) begin bad++; $display("FAIL to_abort: got zeit=%b data=%h want 1 0", Zeitueberschreitung, IDaten); end
      total++;
      ILesen = 1'b0;
      tick();
      if (Zeitueberschreitung !== 1'b0 || IGeladen !== 1'b0) begin bad++; $display("FAIL to_pulse: got zeit=%b done=%b want 0 0", Zeitueberschreitung, IGeladen); end
      total++;
      ram_lat = 1;
      ILesen = 1'b1;
      IAdresse = 8'h10;
      c = 0;
      zs = 0;
      do begin
         tick();
         c++;
         if (Zeitueberschreitung) zs = 1;
      end while (!IGeladen && c < 20);
      if (c !== 3 || IDaten !== 32'hDEAD_BEEF || zs !== 1'b0) begin bad++; $display("FAIL to_recover: got cyc=%0d data=%h zeit=%b want 3 deadbeef 0", c, IDaten, zs); end
      total++;
      ILesen = 1'b0;
      tick();
   endtask

   task automatic test_terminal();
      int c;
      bit zs;
      ram_lat = 7;
      ILesen = 1'b1;
      IAdresse = 8'h20;
      c = 0;
      zs = 0;
      do begin
         tick();
         c++;
         if (Zeitueberschreitung) zs = 1;
      end while (!IGeladen && c < 20);
      if (c !== 9 || IDaten !== 32'hA5A5_0020) begin bad++; $display("FAIL term_data: got cyc=%0d data=%h want 9 a5a50020", c, IDaten); end
      total++;
      if (zs !== 1'b0) begin bad++; $display("FAIL term_no_abort: got %b want 0", zs); end
      total++;
      ILesen = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      int c;
      bit dg;
      ram_lat = 0;
      DLesen = 1'b1;
      DAdresse = 8'h30;
      tick();
      tick();
      if (RAMLesenAn !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", RAMLesenAn); end
      total++;
      #2;
      Reset = 1'b0;
      #1;
      if (RAMLesenAn !== 1'b0 || DDatenRaus !== 32'h0) begin bad++; $display("FAIL mid_async: got rd=%b data=%h want 0 0", RAMLesenAn, DDatenRaus); end
      total++;
      DLesen = 1'b0;
      dg = 0;
      repeat (2) begin tick(); if (DGeladen) dg = 1; end
      Reset = 1'b1;
      repeat (3) begin tick(); if (DGeladen) dg = 1; end
      if (dg !== 1'b0) begin bad++; $display("FAIL mid_no_done: got %b want 0", dg); end
      total++;
      ram_lat = 1;
      ILesen = 1'b1;
      IAdresse = 8'h10;
      DLesen = 1'b1;
      DAdresse = 8'h30;
      c = 0;
      do begin
         tick();
         c++;
      end while (!IGeladen && !DGeladen && c < 20);
      if (c !== 3 || IGeladen !== 1'b1 || DGeladen !== 1'b0) begin bad++; $display("FAIL mid_tie: got cyc=%0d i=%b d=%b want 3 1 0", c, IGeladen, DGeladen); end
      total++;
      ILesen = 1'b0;
      c = 0;
      do begin
         tick();
         c++;
      end while (!DGeladen && c < 20);
      if (c !== 3 || DDatenRaus !== 32'h5A5A_0030) begin bad++; $display("FAIL mid_second: got cyc=%0d data=%h want 3 5a5a0030", c, DDatenRaus); end
      total++;
      DLesen = 1'b0;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single_fetch();
      test_write_read();
      test_contention();
      test_timeout();
      test_terminal();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/speicher_arbiter.md
Name: speicher_arbiter

Overview:
Shares one single-port RAM instance between the CPU instruction-fetch port and the CPU data port, replacing the split instruction/data RAM arrangement. It uses the same level-request / completion-pulse handshake as the RAM and CPU. Arbitration is round-robin between the two ports. A watchdog aborts transactions the RAM never completes, so the CPU cannot hang.

Parameters:
ADDR_W, 8, width of the RAM word address.
DATA_W, 32, data word width.
TIMEOUT, 64, cycles allowed per RAM transaction before abort; 0 disables the watchdog.

Ports:
Clock  in  1  system clock, all flops on rising edge.
Reset  in  1  asynchronous, active-low reset.
ILesen  in  1  instruction read request (level), held until IGeladen.
IAdresse  in  ADDR_W  instruction address, stable while ILesen is high.
IDaten  out  DATA_W  fetched instruction, valid while IGeladen is high.
IGeladen  out  1  instruction read done, 1-cycle pulse.
DLesen  in  1  data read request (level).
DSchreiben  in  1  data write request (level).
DAdresse  in  ADDR_W  data address.
DDatenRein  in  DATA_W  write data.
DDatenRaus  out  DATA_W  read data, valid while DGeladen is high.
DGeladen  out  1  data read done, 1-cycle pulse.
DGespeichert  out  1  data write done, 1-cycle pulse.
RAMLesenAn  out  1  RAM read strobe.
RAMSchreibenAn  out  1  RAM write strobe.
RAMAdresse  out  ADDR_W  RAM address.
RAMDatenRein  out  DATA_W  RAM write data.
RAMDatenRaus  in  DATA_W  RAM read data.
RAMDatenBereit  in  1  RAM read complete.
RAMDatenGeschrieben  in  1  RAM write complete.
Zeitueberschreitung  out  1  watchdog abort, 1-cycle pulse.

Behaviour:
- Reset (Reset low, asynchronous): all outputs 0; state LEERLAUF; watchdog counter 0; last-served flag = DATEN, so the instruction port wins the first tie.
- States:
  - LEERLAUF
  - INSTR
  - DATEN_L
  - DATEN_S
  - ABKLINGEN
- LEERLAUF:
  - Sample requests at each edge.
  - If only one port requests, grant it.
  - If both request, grant the port not served last.
  - On grant, latch address (and write data for a write) into registers and toggle the last-served flag.
  - DSchreiben takes precedence over DLesen if both are high (illegal case; the read is dropped).
- Granted states:
  - Drive RAMAdresse/RAMDatenRein from the latched registers.
  - Drive RAMLesenAn (INSTR, DATEN_L) or RAMSchreibenAn (DATEN_S) high for the entire state.
  - Request inputs are not re-sampled; address changes by the requester are ignored.
- Completion:
  - Sampled at an edge in the granted state: RAMDatenBereit for reads, RAMDatenGeschrieben for writes. The opposite-type completion is ignored.
  - On a read, latch RAMDatenRaus into IDaten/DDatenRaus.
  - Assert the matching done pulse, drop the strobes, go to ABKLINGEN.
- ABKLINGEN:
  - Lasts exactly one cycle; the done pulse is high during this cycle.
  - Next edge: done goes to 0, state goes to LEERLAUF.
  - This gives the requester one edge to drop its request before re-arbitration, so a request is never served twice.
- Read data outputs hold their value until the next completion of the same port.
- Latency:
  - Minimum: grant at edge E0; RAM registers completion at E1; arbiter samples it at E2; done is high in the cycle after E2.
  - A back-to-back request from the other port is granted at E3.
- Watchdog:
  - Counter clears on grant and increments each cycle in a granted state.
  - When the count reaches TIMEOUT-1 with no completion: behave as a completion with read data forced to 0, pulse Zeitueberschreitung together with the done pulse, go to ABKLINGEN.
  - Completion on the terminal cycle wins: normal data, no Zeitueberschreitung.
- Reset asserted mid-transaction: immediate return to reset values, strobes drop asynchronously, the pending transaction is lost with no done pulse.
- Requests dropped before done (protocol violation): the transaction still completes and the done pulse is still issued.

Test Plan:
- Single fetch: RAM[0x10]=0xDEADBEEF, ILesen=1, IAdresse=0x10, 1-cycle RAM → RAMLesenAn high 2 cycles, IGeladen pulse 1 cycle, IDaten=0xDEADBEEF, request-to-done latency 3 edges.
- Write then read: DSchreiben DAdresse=0x05 DDatenRein=0x12345678 → DGespeichert pulse; then DLesen 0x05 → DGeladen, DDatenRaus=0x12345678; RAMLesenAn never high during the write.
- Contention: ILesen and DLesen raised on the same edge, both held and re-requested 4 times → grants alternate I,D,I,D,...; instruction first after reset; no port is served twice in a row while the other waits.
- Timeout: TIMEOUT=8, RAM never completes → abort on the 8th granted cycle, IGeladen and Zeitueberschreitung pulse together, IDaten=0, next request is granted normally.
- Completion on terminal watchdog cycle: RAMDatenBereit arrives exactly at count TIMEOUT-1 → normal data returned, Zeitueberschreitung stays 0.
- Reset mid-read: Reset low while in DATEN_L → RAMLesenAn 0 before the next edge, no DGeladen pulse; after release the last-served flag = DATEN (instruction wins the next tie).
